ecc_decoder: RTL and testbench

- Multi-cycle single-error-correct / double-error-detect (SECDED) Hamming decoder.
- Consumes the 8/16/32-bit codeword format produced by the team's Encoder, possibly after channel noise.
- Recovers the right-aligned data word and reports an error count of 0, 1 or 2.
- Sits directly downstream of the Encoder/noise path, under the same APB-style control: CodeWord_Width, a one-cycle En strobe, and a ready pulse.

---
 rtl/ecc_decoder.sv | 148 ++++++++++++++
 tb/tb_ecc_decoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ecc_decoder.sv
// Multi-cycle SECDED Hamming decoder for the 8/16/32-bit Encoder codeword format.
// Four-state job flow: capture, syndrome, correct/extract, result pulse.
module ecc_decoder #(
    parameter int AMBA_WORD  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [AMBA_WORD-1:0]  CodeWord_Width,
    input  logic                  En,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            num_of_errors,
    output logic                  ready_Decoder,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SYND, CORR, DONE} state_t;

    state_t      state, state_nxt;
    logic        load;
    logic [31:0] cw;
    logic [1:0]  fmt;
    logic [31:0] hv;        // codeword re-laid by Hamming position (bit 0 unused)
    logic [4:0]  syn;
    logic        q;
    logic [31:0] hv_c, fix_c, dext_c;
    logic [4:0]  syn_c;
    logic        q_c;
    logic        unused_cw_width;

    assign unused_cw_width = ^CodeWord_Width[AMBA_WORD-1:2];

    // Scatter the packed codeword (checks low, data high) onto positions 1..2^(P-1)-1.
    function automatic logic [31:0] to_pos(input logic [31:0] c, input logic [1:0] f);
        logic [31:0] h;
        logic [4:0]  k, j, p, np;
        h = '0;
        k = '0;
        j = '0;
        case (f)
            2'b00:   begin np = 5'd7;  p = 5'd4; end
            2'b01:   begin np = 5'd15; p = 5'd5; end
            default: begin np = 5'd31; p = 5'd6; end
        endcase
        for (int pos = 1; pos < 32; pos++) begin
            if (5'(pos) <= np) begin
                if ((pos & (pos - 1)) == 0) begin
                    h[pos] = c[j];
                    j = j + 5'd1;
                end else begin
                    h[pos] = c[p + k];
                    k = k + 5'd1;
                end
            end
        end
        return h;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] h, input logic [1:0] f);
        logic [31:0] d;
        logic [4:0]  k, np;
        d = '0;
        k = '0;
        case (f)
            2'b00:   np = 5'd7;
            2'b01:   np = 5'd15;
            default: np = 5'd31;
        endcase
        for (int pos = 3; pos < 32; pos++) begin
            if (5'(pos) <= np && (pos & (pos - 1)) != 0) begin
                d[k] = h[pos];
                k = k + 5'd1;
            end
        end
        return d;
    endfunction

    always_comb begin
        hv_c  = to_pos(cw, fmt);
        syn_c = '0;
        for (int pos = 1; pos < 32; pos++)
            if (hv_c[pos]) syn_c = syn_c ^ 5'(pos);
        case (fmt)
            2'b00:   q_c = ^cw[7:0];
            2'b01:   q_c = ^cw[15:0];
            default: q_c = ^cw;
        endcase
        fix_c  = (q && syn != 5'd0) ? (hv ^ (32'd1 << syn)) : hv;
        dext_c = extract(fix_c, fmt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: if (En) begin load = 1'b1; state_nxt = SYND; end
            SYND: state_nxt = CORR;
            CORR: state_nxt = DONE;
            DONE: begin
                if (En) begin load = 1'b1; state_nxt = SYND; end
                else    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SYND) || (state == CORR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cw            <= '0;
            fmt           <= '0;
            hv            <= '0;
            syn           <= '0;
            q             <= 1'b0;
            data_out      <= '0;
            num_of_errors <= '0;
            ready_Decoder <= 1'b0;
        end else begin
            ready_Decoder <= (state == CORR);
            if (load) begin
                cw  <= 32'(data_in);
                fmt <= CodeWord_Width[1:0];
            end
            if (state == SYND) begin
                hv  <= hv_c;
                syn <= syn_c;
                q   <= q_c;
            end
            if (state == CORR) begin
                if (fmt == 2'b11) begin
                    data_out      <= '0;
                    num_of_errors <= 2'b00;
                end else begin
                    data_out      <= DATA_WIDTH'(dext_c);
                    num_of_errors <= q ? 2'b01 : ((syn != 5'd0) ? 2'b10 : 2'b00);
                end
            end
        end
    end

endmodule

// File: tb/tb_ecc_decoder.sv
// Directed bench for ecc_decoder: vector table plus multi-cycle control sequences.
module tb_ecc_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic [31:0] CodeWord_Width;
    logic        En;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        ready_Decoder;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ecc_decoder #(.AMBA_WORD(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .CodeWord_Width(CodeWord_Width),
        .En(En), .data_out(data_out), .num_of_errors(num_of_errors),
        .ready_Decoder(ready_Decoder), .busy(busy)
    );

    typedef struct {
        logic [1:0]  fmt;
        logic [31:0] din;
        logic [31:0] exp_d;
        logic [1:0]  exp_e;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Launch a job: En high across exactly one rising edge, then scramble the inputs.
    task automatic start_job(input logic [1:0] f, input logic [31:0] d);
        @(negedge clk);
        CodeWord_Width = {30'b0, f};
        data_in        = d;
        En             = 1'b1;
        @(negedge clk);
        En             = 1'b0;
        data_in        = $urandom;
        CodeWord_Width = $urandom;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ready_Decoder && cyc < 8);
    endtask

    initial begin
        int cyc, pulses;

        // 8-bit: d3..d0 = 1011 encodes to 0xB1
        vecs[0]  = '{2'b00, 32'h0000_00B1, 32'h0000_000B, 2'b00};
        vecs[1]  = '{2'b00, 32'h0000_00A1, 32'h0000_000B, 2'b01};
        vecs[2]  = '{2'b00, 32'h0000_00B9, 32'h0000_000B, 2'b01};
        vecs[3]  = '{2'b00, 32'h0000_0081, 32'h0000_0008, 2'b10};
        vecs[4]  = '{2'b00, 32'h0000_0091, 32'h0000_000B, 2'b01};
        vecs[5]  = '{2'b00, 32'hFFFF_FFB1, 32'h0000_000B, 2'b00};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'h0000_0000, 2'b01};
        vecs[7]  = '{2'b01, 32'h0000_0000, 32'h0000_0000, 2'b00};
        // 16-bit: d0=1 encodes to 0x33; 0x3B flips c3
        vecs[8]  = '{2'b01, 32'h0000_0033, 32'h0000_0001, 2'b00};
        vecs[9]  = '{2'b01, 32'h0000_003B, 32'h0000_0001, 2'b01};
        vecs[10] = '{2'b10, 32'h0000_0000, 32'h0000_0000, 2'b00};
        vecs[11] = '{2'b11, 32'h0000_00B1, 32'h0000_0000, 2'b00};

        reset = 1'b1; En = 1'b0; data_in = '0; CodeWord_Width = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", data_out, 32'h0);
        chk("rst_err", 32'(num_of_errors), 32'h0);
        chk("rst_ready", 32'(ready_Decoder), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            start_job(vecs[i].fmt, vecs[i].din);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
            wait_ready(cyc);
            chk($sformatf("v%0d_latency", i), 32'(cyc), 32'd2);
            chk($sformatf("v%0d_data", i), data_out, vecs[i].exp_d);
            chk($sformatf("v%0d_err", i), 32'(num_of_errors), 32'(vecs[i].exp_e));
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready_width", i), 32'(ready_Decoder), 32'h0);
        end

        // En re-pulsed while in SYND must be ignored
        start_job(2'b00, 32'hB1);
        En = 1'b1;
        @(negedge clk);
        En = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ready_Decoder) pulses++;
        end
        chk("repulse_count", 32'(pulses), 32'd1);
        chk("repulse_data", data_out, 32'hB);

        // En during DONE: back-to-back job, ready 3 cycles after the first
        start_job(2'b00, 32'hB1);
        wait_ready(cyc);
        chk("b2b_first_latency", 32'(cyc), 32'd2);
        CodeWord_Width = 32'h0;
        data_in        = 32'h81;
        En             = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            En = 1'b0;
            cyc++;
        end while (!ready_Decoder && cyc < 8);
        chk("b2b_gap", 32'(cyc), 32'd3);
        chk("b2b_data", data_out, 32'h8);
        chk("b2b_err", 32'(num_of_errors), 32'h2);

        // Reset in CORR aborts the job and clears the outputs immediately
        start_job(2'b00, 32'hA1);
        @(posedge clk); #1;
        chk("abort_busy_pre", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("abort_data", data_out, 32'h0);
        chk("abort_err", 32'(num_of_errors), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ready_Decoder) pulses++;
        end
        chk("abort_no_ready", 32'(pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
